semaforo_ctrl: RTL and testbench
================================

# semaforo_ctrl

Parametrised, timed traffic-light controller for N approaches. It replaces the purely combinational two-way sensor-to-light mapping with a registered Moore state machine. The machine has minimum and maximum green times, a yellow phase and an optional all-red clearance. Service among waiting approaches is round-robin. It sits between the vehicle-sensor inputs and the lamp drivers of an intersection.

## Interface
- N_WAYS, 2: number of approaches (2..8).
- T_GREEN_MIN, 4: minimum green duration in cycles (≥1).
- T_GREEN_MAX, 12: maximum green duration in cycles when others are waiting (≥T_GREEN_MIN).
- T_YELLOW, 2: yellow duration in cycles (≥1).
- T_ALL_RED, 1: all-red clearance in cycles (≥1; used only with the macro).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- car  in  N_WAYS  level sensor; bit i high means a vehicle is waiting at approach i.
- green  out  N_WAYS  green lamp per approach.
- yellow  out  N_WAYS  yellow lamp per approach.
- red  out  N_WAYS  red lamp per approach.
- active  out  max(1,$clog2(N_WAYS))  index of the approach currently holding right of way.

## Operation
- The design has one clock and one asynchronous, active-high reset.
- All outputs are decoded from registered state, active index and timer (Moore); there is no combinational path from car to the lamps.
- Per approach, exactly one of green/yellow/red is high. At most one approach is non-red at any time.
- Reset values:
  - state=GREEN, active=0, timer=0, pend=0.
  - green=1, yellow=0, red=~1 (one-hot on way 0).
- Reset asserted mid-phase returns to these values immediately.
- Pending requests, register pend[N_WAYS]:
  - pend[i] ← (pend[i] | car[i]) & ~(state==GREEN && active==i).
  - The way being served in GREEN never accumulates a request.
  - A car arriving during its own YELLOW/ALL_RED sets pend and is served in a later turn.
- other = |(pend & ~onehot(active)).
- timer counts cycles in the current phase. It is 0 on the first cycle of each phase and saturates at T_GREEN_MAX-1 in GREEN. Width is $clog2(max(T_GREEN_MAX,T_YELLOW,T_ALL_RED)+1).
- GREEN, exit to YELLOW when all of the following hold:
  - other=1, and
  - timer ≥ T_GREEN_MIN-1, and
  - car[active]=0 (gap-out) or timer = T_GREEN_MAX-1 (max-out).
- GREEN with other=0: hold green indefinitely, regardless of car[active].
- On exit from GREEN, next is latched as the first pending way scanning active+1, active+2, … with wrap-around modulo N_WAYS, excluding active.
- YELLOW: after T_YELLOW cycles go to ALL_RED (macro set) or GREEN (macro clear).
- ALL_RED: all red, active unchanged, lasts T_ALL_RED cycles, then GREEN.
- Entering GREEN sets active←next and timer←0. pend[next] clears on the following edge.
- car is sampled synchronously; an upstream block synchronises it.

## Timing
- Phase lengths are exact:
  - GREEN ≥ T_GREEN_MIN cycles.
  - YELLOW = T_YELLOW cycles.
  - ALL_RED = T_ALL_RED cycles.
- Latency from the request edge (pend set) to the green decision is 1 cycle. The exit decision uses pend registered on the previous edge.
- Example: N_WAYS=2, defaults, macro set, car=2'b10 held from the first post-reset edge.
  - green[0] high for cycles 0–3.
  - yellow[0] high for cycles 4–5.
  - All red at cycle 6.
  - green[1] high and active=1 from cycle 7.
- Lamp transitions are glitch-free because every lamp is a registered decode.

## Configuration
- SEMAFORO_ALL_RED_EN defined: the ALL_RED state and T_ALL_RED are compiled in, and YELLOW→ALL_RED→GREEN.
- SEMAFORO_ALL_RED_EN undefined: YELLOW→GREEN directly, and T_ALL_RED is ignored.
- The example above then gives green[1] from cycle 6.

## Structure
- semaforo_pkg holds:
  - the typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} fase_t;
  - the localparam MAX_WAYS=8;
  - the onehot function.
- Sub-module semaforo_rr:
  - combinational round-robin selector;
  - inputs: pend, active;
  - output: next index;
  - N_WAYS parameter.
- The top holds the FSM, timer, pend register and lamp decode.

## Test plan
- Reset with car=0 for 50 cycles → green[0]=1 throughout, active=0, no yellow.
- N_WAYS=2, car=2'b10 pulsed one cycle → pend latches; green[0] for 4 cycles, yellow 2, all-red 1, green[1] at cycle 7.
- car=2'b11 held (own car stays) → way 0 max-outs at 12 green cycles, then yellow; each way alternates at 12-cycle greens.
- N_WAYS=4, active=1, car=4'b1001 → next=3 (wrap order 2,3,0), then 0.
- reset asserted during YELLOW of way 2 → outputs return asynchronously to green[0], pend=0 before the next edge.
- Build without SEMAFORO_ALL_RED_EN, scenario 2 → green[1] at cycle 6; assert no cycle has all lamps red.

Source files
------------

// File: rtl/semaforo_pkg.sv
// Shared types and helpers for the semaforo traffic-light controller.
package semaforo_pkg;

    typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} fase_t;

    localparam int MAX_WAYS = 8;

    function automatic logic [MAX_WAYS-1:0] onehot(input logic [2:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/semaforo_rr.sv
// Round-robin selector: first pending approach after the active one, with wrap-around.
module semaforo_rr #(
    parameter  int N_WAYS = 2,
    localparam int AW     = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic [N_WAYS-1:0] pend,
    input  logic [AW-1:0]     active,
    output logic [AW-1:0]     next
);

    logic          found;
    logic [AW-1:0] idx;

    always_comb begin
        next  = active;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k < N_WAYS; k++) begin
            idx = AW'((int'(active) + k) % N_WAYS);
            if (!found && pend[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaforo_ctrl.sv
// Timed round-robin traffic-light controller for N approaches (registered Moore FSM).
// Define SEMAFORO_ALL_RED_EN to insert an all-red clearance phase after yellow.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter  int N_WAYS      = 2,
    parameter  int T_GREEN_MIN = 4,
    parameter  int T_GREEN_MAX = 12,
    parameter  int T_YELLOW    = 2,
    parameter  int T_ALL_RED   = 1,
    localparam int AW          = (N_WAYS > 1) ? $clog2(N_WAYS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_WAYS-1:0] car,
    output logic [N_WAYS-1:0] green,
    output logic [N_WAYS-1:0] yellow,
    output logic [N_WAYS-1:0] red,
    output logic [AW-1:0]     active
);

    localparam int T_GY  = (T_GREEN_MAX > T_YELLOW) ? T_GREEN_MAX : T_YELLOW;
    localparam int T_ALL = (T_GY > T_ALL_RED) ? T_GY : T_ALL_RED;
    localparam int TW    = $clog2(T_ALL + 1);

    localparam logic [TW-1:0] TG_MIN_L = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] TG_MAX_L = TW'(T_GREEN_MAX - 1);
    localparam logic [TW-1:0] TY_L     = TW'(T_YELLOW - 1);
`ifdef SEMAFORO_ALL_RED_EN
    localparam logic [TW-1:0] TAR_L    = TW'(T_ALL_RED - 1);
`endif

    fase_t             state_q, state_d;
    logic [AW-1:0]     active_q, active_d;
    logic [AW-1:0]     next_q, next_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_WAYS-1:0] pend_q, pend_d;

    logic [MAX_WAYS-1:0] oh;
    logic [N_WAYS-1:0]   oh_n;
    logic [AW-1:0]       rr_next;
    logic                other;

    semaforo_rr #(.N_WAYS(N_WAYS)) u_rr (
        .pend   (pend_q),
        .active (active_q),
        .next   (rr_next)
    );

    always_comb begin
        oh    = onehot(3'(active_q));
        oh_n  = oh[N_WAYS-1:0];
        other = |(pend_q & ~oh_n);
    end

    // The way holding green never accumulates a request of its own.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < N_WAYS; i++) begin
            pend_d[i] = (pend_q[i] | car[i]) & ~(state_q == GREEN && active_q == AW'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        next_d   = next_q;
        timer_d  = timer_q;
        case (state_q)
            GREEN: begin
                timer_d = (timer_q == TG_MAX_L) ? timer_q : timer_q + 1'b1;
                if (other && timer_q >= TG_MIN_L && (!car[active_q] || timer_q == TG_MAX_L)) begin
                    state_d = YELLOW;
                    timer_d = '0;
                    next_d  = rr_next;
                end
            end
            YELLOW: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TY_L) begin
                    timer_d = '0;
`ifdef SEMAFORO_ALL_RED_EN
                    state_d = ALL_RED;
`else
                    state_d  = GREEN;
                    active_d = next_q;
`endif
                end
            end
`ifdef SEMAFORO_ALL_RED_EN
            ALL_RED: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == TAR_L) begin
                    timer_d  = '0;
                    state_d  = GREEN;
                    active_d = next_q;
                end
            end
`endif
            default: begin
                state_d = GREEN;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= GREEN;
            active_q <= '0;
            next_q   <= '0;
            timer_q  <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        case (state_q)
            GREEN: begin
                green = oh_n;
                red   = ~oh_n;
            end
            YELLOW: begin
                yellow = oh_n;
                red    = ~oh_n;
            end
            default: ;
        endcase
        active = active_q;
    end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl: 2-way and 4-way instances, hand-computed lamp timelines.
module tb_semaforo_ctrl;

`ifdef SEMAFORO_ALL_RED_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset2, reset4;
    logic [1:0] car2, g2, y2, r2;
    logic [0:0] a2;
    logic [3:0] car4, g4, y4, r4;
    logic [1:0] a4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    semaforo_ctrl #(.N_WAYS(2)) dut2 (
        .clk(clk), .reset(reset2), .car(car2),
        .green(g2), .yellow(y2), .red(r2), .active(a2)
    );

    semaforo_ctrl #(.N_WAYS(4)) dut4 (
        .clk(clk), .reset(reset4), .car(car4),
        .green(g4), .yellow(y4), .red(r4), .active(a4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves both DUTs out of reset at #1 after an edge: the current cycle is cycle 0.
    task automatic do_reset();
        reset2 = 1'b1;
        reset4 = 1'b1;
        car2   = '0;
        car4   = '0;
        repeat (2) tick();
        reset2 = 1'b0;
        reset4 = 1'b0;
    endtask

    initial begin
        logic [1:0] eg, ey, er;
        logic [0:0] ea;
        int p, w, ph;

        // Idle: green stays on way 0
        do_reset();
        for (int k = 0; k < 50; k++) begin
            chk("idle_green", 32'(g2), 32'h1);
            chk("idle_yellow", 32'(y2), 32'h0);
            chk("idle_active", 32'(a2), 32'h0);
            tick();
        end

        // One-cycle request on way 1
        do_reset();
        car2 = 2'b10;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) begin
                eg = 2'b01; ey = 2'b00; er = 2'b10; ea = 1'b0;
            end else if (k < 6) begin
                eg = 2'b00; ey = 2'b01; er = 2'b10; ea = 1'b0;
            end else if (k < 6 + AR) begin
                eg = 2'b00; ey = 2'b00; er = 2'b11; ea = 1'b0;
            end else begin
                eg = 2'b10; ey = 2'b00; er = 2'b01; ea = 1'b1;
            end
            chk("pulse_green", 32'(g2), 32'(eg));
            chk("pulse_yellow", 32'(y2), 32'(ey));
            chk("pulse_red", 32'(r2), 32'(er));
            chk("pulse_active", 32'(a2), 32'(ea));
            tick();
            car2 = 2'b00;
        end
        repeat (10) tick();
        chk("pulse_hold_green", 32'(g2), 32'h2);

        // Both ways held: alternating max-out greens
        do_reset();
        car2 = 2'b11;
        p = 14 + AR;
        for (int k = 0; k < 3 * p; k++) begin
            w  = (k / p) % 2;
            ph = k % p;
            eg = 2'b00; ey = 2'b00; er = 2'b11;
            if (ph < 12) begin
                eg = (w == 0) ? 2'b01 : 2'b10;
                er = ~eg;
            end else if (ph < 14) begin
                ey = (w == 0) ? 2'b01 : 2'b10;
                er = ~ey;
            end
            chk("maxout_green", 32'(g2), 32'(eg));
            chk("maxout_yellow", 32'(y2), 32'(ey));
            chk("maxout_red", 32'(r2), 32'(er));
            chk("maxout_active", 32'(a2), 32'(w));
            tick();
        end

        // 4 ways: from active=1 with requests on 0 and 3, serve 3 then 0
        do_reset();
        car4 = 4'b0010;
        tick();
        car4 = 4'b0000;
        repeat (5 + AR) tick();
        chk("rr4_g1_active", 32'(a4), 32'h1);
        chk("rr4_g1_green", 32'(g4), 32'h2);
        car4 = 4'b1001;
        repeat (3) tick();
        chk("rr4_gapout_green", 32'(g4), 32'h2);
        tick();
        chk("rr4_y1_yellow", 32'(y4), 32'h2);
        repeat (2 + AR) tick();
        chk("rr4_g3_active", 32'(a4), 32'h3);
        chk("rr4_g3_green", 32'(g4), 32'h8);
        repeat (11) tick();
        chk("rr4_g3_max_green", 32'(g4), 32'h8);
        tick();
        chk("rr4_y3_yellow", 32'(y4), 32'h8);
        repeat (2 + AR) tick();
        chk("rr4_g0_active", 32'(a4), 32'h0);
        chk("rr4_g0_green", 32'(g4), 32'h1);

        // Asynchronous reset during yellow of way 2
        do_reset();
        car4 = 4'b0100;
        tick();
        car4 = 4'b0000;
        repeat (5 + AR) tick();
        chk("rst_g2_active", 32'(a4), 32'h2);
        car4 = 4'b0001;
        repeat (4) tick();
        chk("rst_y2_yellow", 32'(y4), 32'h4);
        #2;
        reset4 = 1'b1;
        #1;
        chk("rst_async_green", 32'(g4), 32'h1);
        chk("rst_async_yellow", 32'(y4), 32'h0);
        chk("rst_async_red", 32'(r4), 32'he);
        chk("rst_async_active", 32'(a4), 32'h0);
        chk("rst_async_pend", 32'(dut4.pend_q), 32'h0);
        car4 = 4'b0000;
        tick();
        reset4 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
